mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/arb_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// FSM states, default timeout and downstream size codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arbstate_t;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] OPLEN_BYTE = 2'd0;
  localparam logic [1:0] OPLEN_HALF = 2'd1;
  localparam logic [1:0] OPLEN_WORD = 2'd2;

endpackage

// File: rtl/arb_watchdog.sv
// Per-transaction cycle counter for the memory port arbiter.
// Cleared on grant, counts busy cycles, flags the last allowed one.
module arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  // Count busy cycles since the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Busy cycle LIMIT without completion ends the transaction.
  assign expire = inc && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between fetch and data.
// Round-robin on ties, one transaction in flight, timeout abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_enable,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_we,
  input  logic              d_unsigned,
  input  logic [1:0]        d_oplen,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              m_enable,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [31:0]       m_wdata,
  output logic [1:0]        m_oplen,
  output logic              m_unsigned,
  input  logic              m_valid,
  input  logic [31:0]       m_rdata,
  output logic              err,
  output logic              grant_d
);

  arbstate_t state;
  logic      last_d;
  logic      req;
  logic      pick_d;
  logic      wd_clr;
  logic      wd_inc;
  logic      wd_expire;

  // Data wins when alone, or on a tie if instr went last.
  assign req    = i_enable || d_enable;
  assign pick_d = d_enable && (!i_enable || !last_d);
  assign wd_clr = (state == ARB_IDLE) && req;
  assign wd_inc = (state == ARB_BUSY) && !m_valid;

  arb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  // Arbitration FSM with registered downstream and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_d     <= 1'b1;
      grant_d    <= 1'b0;
      m_enable   <= 1'b0;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_wdata    <= '0;
      m_oplen    <= '0;
      m_unsigned <= 1'b0;
      i_valid    <= 1'b0;
      i_rdata    <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (req) begin
            state    <= ARB_BUSY;
            m_enable <= 1'b1;
            grant_d  <= pick_d;
            last_d   <= pick_d;
            if (pick_d) begin
              m_addr     <= d_addr;
              m_we       <= d_we;
              m_wdata    <= d_wdata;
              m_oplen    <= d_oplen;
              m_unsigned <= d_unsigned;
            end else begin
              m_addr     <= i_addr;
              m_we       <= 1'b0;
              m_wdata    <= '0;
              m_oplen    <= OPLEN_WORD;
              m_unsigned <= 1'b0;
            end
          end
        end
        ARB_BUSY: begin
          if (m_valid) begin
            state    <= ARB_RESP;
            m_enable <= 1'b0;
            if (grant_d) begin
              d_valid <= 1'b1;
              d_rdata <= m_rdata;
            end else begin
              i_valid <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else if (wd_expire) begin
            state    <= ARB_RESP;
            m_enable <= 1'b0;
            err      <= 1'b1;
            if (grant_d) begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_valid <= 1'b1;
              i_rdata <= '0;
            end
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4.
// Linear steps, hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_enable;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_unsigned;
  logic [1:0]  d_oplen;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        m_enable;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [1:0]  m_oplen;
  logic        m_unsigned;
  logic        m_valid;
  logic [31:0] m_rdata;
  logic        err;
  logic        grant_d;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(
    .TIMEOUT (4),
    .ADDR_W  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (i_enable),
    .i_addr     (i_addr),
    .i_valid    (i_valid),
    .i_rdata    (i_rdata),
    .d_enable   (d_enable),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_we       (d_we),
    .d_unsigned (d_unsigned),
    .d_oplen    (d_oplen),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .m_enable   (m_enable),
    .m_addr     (m_addr),
    .m_we       (m_we),
    .m_wdata    (m_wdata),
    .m_oplen    (m_oplen),
    .m_unsigned (m_unsigned),
    .m_valid    (m_valid),
    .m_rdata    (m_rdata),
    .err        (err),
    .grant_d    (grant_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_enable = 1'b0;
    i_addr = '0;
    d_enable = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_we = 1'b0;
    d_unsigned = 1'b0;
    d_oplen = '0;
    m_valid = 1'b0;
    m_rdata = '0;

    #3;
    chk("rst_m_enable", 32'(m_enable), 32'h0);
    chk("rst_grant_d", 32'(grant_d), 32'h0);
    chk("rst_i_valid", 32'(i_valid), 32'h0);
    chk("rst_d_valid", 32'(d_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_m_oplen", 32'(m_oplen), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // single fetch, completion after 3 busy cycles
    i_enable = 1'b1;
    i_addr = 32'h100;
    step();
    chk("f_m_enable", 32'(m_enable), 32'h1);
    chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_we", 32'(m_we), 32'h0);
    chk("f_m_oplen", 32'(m_oplen), 32'h2);
    chk("f_grant_d", 32'(grant_d), 32'h0);
    i_enable = 1'b0;
    i_addr = 32'h999;
    step();
    chk("f_hold1", 32'(m_enable), 32'h1);
    step();
    chk("f_hold2", 32'(m_enable), 32'h1);
    chk("f_addr_stable", m_addr, 32'h100);
    m_valid = 1'b1;
    m_rdata = 32'h00000013;
    step();
    chk("f_i_valid", 32'(i_valid), 32'h1);
    chk("f_i_rdata", i_rdata, 32'h00000013);
    chk("f_d_valid", 32'(d_valid), 32'h0);
    chk("f_m_enable_off", 32'(m_enable), 32'h0);
    m_valid = 1'b0;
    step();
    chk("f_i_valid_pulse", 32'(i_valid), 32'h0);

    // reset again so the tie sees the reset last-grant
    rst_n = 1'b0;
    #1;
    chk("rst2_i_rdata", i_rdata, 32'h0);
    rst_n = 1'b1;

    // tie: instr first, data next
    i_enable = 1'b1;
    i_addr = 32'h40;
    d_enable = 1'b1;
    d_addr = 32'h3000;
    d_we = 1'b0;
    d_oplen = 2'd1;
    d_unsigned = 1'b1;
    step();
    chk("t_grant_i", 32'(grant_d), 32'h0);
    chk("t_m_addr_i", m_addr, 32'h40);
    m_valid = 1'b1;
    m_rdata = 32'hAAAA5555;
    step();
    chk("t_i_valid", 32'(i_valid), 32'h1);
    chk("t_d_valid_lo", 32'(d_valid), 32'h0);
    m_valid = 1'b0;
    i_enable = 1'b0;
    step();
    chk("t_resp_m_en", 32'(m_enable), 32'h0);
    step();
    chk("t_grant_d", 32'(grant_d), 32'h1);
    chk("t_m_addr_d", m_addr, 32'h3000);
    chk("t_m_oplen_d", 32'(m_oplen), 32'h1);
    chk("t_m_unsigned", 32'(m_unsigned), 32'h1);
    m_valid = 1'b1;
    m_rdata = 32'h00001234;
    step();
    chk("t_d_valid", 32'(d_valid), 32'h1);
    chk("t_d_rdata", d_rdata, 32'h00001234);
    chk("t_i_rdata_kept", i_rdata, 32'hAAAA5555);
    chk("t_i_valid_lo", 32'(i_valid), 32'h0);
    m_valid = 1'b0;
    d_enable = 1'b0;
    step();
    chk("t_d_valid_once", 32'(d_valid), 32'h0);

    // store with field stability
    d_enable = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    d_oplen = 2'd2;
    d_unsigned = 1'b0;
    step();
    chk("s_m_we", 32'(m_we), 32'h1);
    chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("s_m_addr", m_addr, 32'h2000);
    d_addr = 32'h5555;
    d_wdata = 32'h0;
    d_we = 1'b0;
    step();
    chk("s_addr_stable", m_addr, 32'h2000);
    chk("s_wdata_stable", m_wdata, 32'hDEADBEEF);
    chk("s_we_stable", 32'(m_we), 32'h1);
    m_valid = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    step();
    chk("s_d_valid", 32'(d_valid), 32'h1);
    chk("s_m_en_off1", 32'(m_enable), 32'h0);
    m_valid = 1'b0;
    d_enable = 1'b0;
    step();
    chk("s_d_valid_pulse", 32'(d_valid), 32'h0);
    chk("s_m_en_off2", 32'(m_enable), 32'h0);
    chk("s_err", 32'(err), 32'h0);

    // timeout with TIMEOUT=4
    d_enable = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h80;
    step();
    chk("to_busy1", 32'(m_enable), 32'h1);
    step();
    chk("to_busy2", 32'(m_enable), 32'h1);
    step();
    chk("to_busy3", 32'(m_enable), 32'h1);
    step();
    chk("to_busy4", 32'(m_enable), 32'h1);
    chk("to_no_err_yet", 32'(err), 32'h0);
    step();
    chk("to_err", 32'(err), 32'h1);
    chk("to_d_valid", 32'(d_valid), 32'h1);
    chk("to_d_rdata", d_rdata, 32'h0);
    chk("to_m_en_off", 32'(m_enable), 32'h0);
    d_enable = 1'b0;
    step();
    chk("to_err_pulse", 32'(err), 32'h0);
    chk("to_dv_pulse", 32'(d_valid), 32'h0);

    // stray m_valid in idle
    m_valid = 1'b1;
    step();
    chk("stray_i_valid", 32'(i_valid), 32'h0);
    chk("stray_d_valid", 32'(d_valid), 32'h0);
    chk("stray_err", 32'(err), 32'h0);
    m_valid = 1'b0;

    // async reset during busy
    i_enable = 1'b1;
    i_addr = 32'h200;
    step();
    chk("ar_busy", 32'(m_enable), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_m_enable", 32'(m_enable), 32'h0);
    chk("ar_m_addr", m_addr, 32'h0);
    chk("ar_d_rdata", d_rdata, 32'h0);
    i_enable = 1'b0;
    #2;
    rst_n = 1'b1;
    m_valid = 1'b1;
    m_rdata = 32'h77;
    step();
    chk("ar_late_i_valid", 32'(i_valid), 32'h0);
    chk("ar_late_err", 32'(err), 32'h0);
    m_valid = 1'b0;
    step();
    chk("ar_late_i_valid2", 32'(i_valid), 32'h0);

    // continuous tie load alternates I,D,I,D,I,D
    i_enable = 1'b1;
    d_enable = 1'b1;
    i_addr = 32'h1000;
    d_addr = 32'h8000;
    d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = k[0];
      step();
      chk($sformatf("rr_grant%0d", k), 32'(grant_d), 32'(exp_d));
      chk($sformatf("rr_addr%0d", k), m_addr,
          exp_d ? 32'h8000 : 32'h1000);
      m_valid = 1'b1;
      m_rdata = 32'(k + 1);
      step();
      chk($sformatf("rr_iv%0d", k), 32'(i_valid), 32'(!exp_d));
      chk($sformatf("rr_dv%0d", k), 32'(d_valid), 32'(exp_d));
      m_valid = 1'b0;
      step();
      chk($sformatf("rr_both%0d", k), 32'(i_valid & d_valid), 32'h0);
    end
    i_enable = 1'b0;
    d_enable = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
